mc_maindec: RTL and testbench

- Multicycle MIPS main controller FSM. It sequences each instruction through fetch, decode, execute, memory and writeback.
- It is the producer side of the aluop interface. It drives the 2-bit aluop consumed by the ALU decoder, plus all datapath mux selects and write enables.
- Sits between the instruction register opcode field, the memory ready handshake and the multicycle datapath.

---
 rtl/mc_maindec.sv | 154 +++++++++++++++
 tb/tb_mc_maindec.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mc_maindec.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// and drives the ALU-decoder aluop plus all datapath selects and write enables.
module mc_maindec #(
   parameter bit WAIT_MEM = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       memready,
   output logic [1:0] aluop,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       iord,
   output logic       regdst,
   output logic       memtoreg,
   output logic       irwrite,
   output logic       regwrite,
   output logic       memwrite,
   output logic       pcen,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t cur, nxt;
   logic   ready;
   logic   pcwrite, branch;
   logic   irwrite_raw, regwrite_raw, memwrite_raw, illegal_raw;

   assign ready = WAIT_MEM ? memready : 1'b1;

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur <= FETCH;
      else       cur <= nxt;
   end

   // NOTE: every signal gets a default before the case, so no path leaves it unassigned (no latch).
   always_comb begin
      nxt         = FETCH;
      illegal_raw = 1'b0;
      case (cur)
         FETCH:   nxt = ready ? DECODE : FETCH;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: nxt = MEMADR;
               OP_RTYPE:     nxt = RTYPEEX;
               OP_BEQ:       nxt = BEQEX;
               OP_ADDI:      nxt = ADDIEX;
               OP_J:         nxt = JEX;
               default:      illegal_raw = 1'b1;
            endcase
         end
         MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   nxt = ready ? MEMWB : MEMRD;
         MEMWR:   nxt = ready ? FETCH : MEMWR;
         RTYPEEX: nxt = RTYPEWB;
         ADDIEX:  nxt = ADDIWB;
         default: nxt = FETCH;
      endcase
   end

   always_comb begin
      aluop        = 2'b00;
      alusrca      = 1'b0;
      alusrcb      = 2'b00;
      pcsrc        = 2'b00;
      iord         = 1'b0;
      regdst       = 1'b0;
      memtoreg     = 1'b0;
      irwrite_raw  = 1'b0;
      regwrite_raw = 1'b0;
      memwrite_raw = 1'b0;
      pcwrite      = 1'b0;
      branch       = 1'b0;
      case (cur)
         FETCH: begin
            alusrcb     = 2'b01;
            irwrite_raw = ready;
            pcwrite     = ready;
         end
         DECODE:  alusrcb = 2'b11;
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD:   iord = 1'b1;
         MEMWB: begin
            memtoreg     = 1'b1;
            regwrite_raw = 1'b1;
         end
         MEMWR: begin
            iord         = 1'b1;
            memwrite_raw = 1'b1;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         RTYPEWB: begin
            regdst       = 1'b1;
            regwrite_raw = 1'b1;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         ADDIWB:  regwrite_raw = 1'b1;
         JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   // Write enables are suppressed combinationally so nothing strobes while reset is high.
   assign irwrite  = irwrite_raw  & ~reset;
   assign regwrite = regwrite_raw & ~reset;
   assign memwrite = memwrite_raw & ~reset;
   assign illegal  = illegal_raw  & ~reset;
   assign pcen     = ~reset & (pcwrite | (branch & zero));
   assign state    = cur;

endmodule

// File: tb/tb_mc_maindec.sv
// Table-driven bench for mc_maindec: per-cycle expected outputs through a scoreboard queue,
// plus hand sequences for asynchronous reset and the WAIT_MEM = 0 variant.
module tb_mc_maindec;

   typedef struct packed {
      logic [3:0] state;
      logic [1:0] aluop;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic       iord;
      logic       regdst;
      logic       memtoreg;
      logic       irwrite;
      logic       regwrite;
      logic       memwrite;
      logic       pcen;
      logic       illegal;
   } out_t;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic       mr;
      logic       z;
      out_t       exp;
   } vec_t;

   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] BAD  = 6'b111111;

   localparam out_t F0      = '{state: 4'd0, alusrcb: 2'b01, default: '0};
   localparam out_t F1      = '{state: 4'd0, alusrcb: 2'b01, irwrite: 1'b1, pcen: 1'b1, default: '0};
   localparam out_t DEC     = '{state: 4'd1, alusrcb: 2'b11, default: '0};
   localparam out_t DEC_ILL = '{state: 4'd1, alusrcb: 2'b11, illegal: 1'b1, default: '0};
   localparam out_t MADR    = '{state: 4'd2, alusrca: 1'b1, alusrcb: 2'b10, default: '0};
   localparam out_t MRD     = '{state: 4'd3, iord: 1'b1, default: '0};
   localparam out_t MWB     = '{state: 4'd4, memtoreg: 1'b1, regwrite: 1'b1, default: '0};
   localparam out_t MWR     = '{state: 4'd5, iord: 1'b1, memwrite: 1'b1, default: '0};
   localparam out_t REX     = '{state: 4'd6, aluop: 2'b10, alusrca: 1'b1, default: '0};
   localparam out_t RWB     = '{state: 4'd7, regdst: 1'b1, regwrite: 1'b1, default: '0};
   localparam out_t BEQ_Z   = '{state: 4'd8, aluop: 2'b01, alusrca: 1'b1, pcsrc: 2'b01, pcen: 1'b1, default: '0};
   localparam out_t BEQ_NZ  = '{state: 4'd8, aluop: 2'b01, alusrca: 1'b1, pcsrc: 2'b01, default: '0};
   localparam out_t AEX     = '{state: 4'd9, alusrca: 1'b1, alusrcb: 2'b10, default: '0};
   localparam out_t AWB     = '{state: 4'd10, regwrite: 1'b1, default: '0};
   localparam out_t JX      = '{state: 4'd11, pcsrc: 2'b10, pcen: 1'b1, default: '0};

   logic       clk = 1'b0;
   logic       reset, zero, memready;
   logic [5:0] op, op0;

   logic [1:0] aluop, alusrcb, pcsrc;
   logic       alusrca, iord, regdst, memtoreg, irwrite, regwrite, memwrite, pcen, illegal;
   logic [3:0] state;

   logic [1:0] n_aluop, n_alusrcb, n_pcsrc;
   logic       n_alusrca, n_iord, n_regdst, n_memtoreg, n_irwrite, n_regwrite, n_memwrite, n_pcen, n_illegal;
   logic [3:0] n_state;

   out_t act;
   assign act = {state, aluop, alusrca, alusrcb, pcsrc, iord, regdst, memtoreg,
                 irwrite, regwrite, memwrite, pcen, illegal};

   always #5 clk = ~clk;

   mc_maindec #(.WAIT_MEM(1'b1)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
      .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .iord(iord),
      .regdst(regdst), .memtoreg(memtoreg), .irwrite(irwrite), .regwrite(regwrite),
      .memwrite(memwrite), .pcen(pcen), .illegal(illegal), .state(state)
   );

   // Memory never signals ready here; this instance must ignore it.
   mc_maindec #(.WAIT_MEM(1'b0)) dut0 (
      .clk(clk), .reset(reset), .op(op0), .zero(1'b0), .memready(1'b0),
      .aluop(n_aluop), .alusrca(n_alusrca), .alusrcb(n_alusrcb), .pcsrc(n_pcsrc), .iord(n_iord),
      .regdst(n_regdst), .memtoreg(n_memtoreg), .irwrite(n_irwrite), .regwrite(n_regwrite),
      .memwrite(n_memwrite), .pcen(n_pcen), .illegal(n_illegal), .state(n_state)
   );

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   vec_t exp_q[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic add(input string name, input logic [5:0] o, input logic mr, input logic z,
                      input out_t e);
      vec_t v;
      v.name = name; v.op = o; v.mr = mr; v.z = z; v.exp = e;
      vecs.push_back(v);
   endtask

   // Drive one cycle's inputs just after the falling edge, compare 1 time unit later.
   task automatic apply(input vec_t v);
      vec_t e;
      op       = v.op;
      memready = v.mr;
      zero     = v.z;
      exp_q.push_back(v);
      #1;
      e = exp_q.pop_front();
      check(e.name, 32'(act), 32'(e.exp));
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] exp_st [6];
      logic       exp_rw [6];
      exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      exp_rw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      reset = 1'b1; op = LW; op0 = LW; memready = 1'b1; zero = 1'b0;
      @(negedge clk);
      #1 check("reset_held", 32'(act), 32'(F0));
      @(negedge clk);
      reset = 1'b0;

      add("lw_fetch",  LW, 1'b1, 1'b0, F1);
      add("lw_decode", LW, 1'b1, 1'b0, DEC);
      add("lw_memadr", LW, 1'b1, 1'b0, MADR);
      add("lw_memrd",  LW, 1'b1, 1'b0, MRD);
      add("lw_memwb",  LW, 1'b1, 1'b0, MWB);
      add("rt_fetch",  RT, 1'b1, 1'b0, F1);
      add("rt_decode", RT, 1'b1, 1'b0, DEC);
      add("rt_ex",     RT, 1'b1, 1'b1, REX);
      add("rt_wb",     RT, 1'b1, 1'b0, RWB);
      add("beqz_fetch", BEQ, 1'b1, 1'b0, F1);
      add("beqz_decode", BEQ, 1'b1, 1'b0, DEC);
      add("beqz_ex",   BEQ, 1'b1, 1'b1, BEQ_Z);
      add("beqn_fetch", BEQ, 1'b1, 1'b1, F1);
      add("beqn_decode", BEQ, 1'b1, 1'b1, DEC);
      add("beqn_ex",   BEQ, 1'b1, 1'b0, BEQ_NZ);
      add("sw_fetch",  SW, 1'b1, 1'b0, F1);
      add("sw_decode", SW, 1'b1, 1'b0, DEC);
      add("sw_memadr", SW, 1'b1, 1'b0, MADR);
      add("sw_stall1", SW, 1'b0, 1'b0, MWR);
      add("sw_stall2", SW, 1'b0, 1'b0, MWR);
      add("sw_stall3", SW, 1'b0, 1'b0, MWR);
      add("sw_done",   SW, 1'b1, 1'b0, MWR);
      add("fetch_stall1", ADDI, 1'b0, 1'b1, F0);
      add("fetch_stall2", ADDI, 1'b0, 1'b0, F0);
      add("addi_fetch",  ADDI, 1'b1, 1'b0, F1);
      add("addi_decode", ADDI, 1'b1, 1'b0, DEC);
      add("addi_ex",     ADDI, 1'b1, 1'b0, AEX);
      add("addi_wb",     ADDI, 1'b1, 1'b0, AWB);
      add("ill_fetch",  BAD, 1'b1, 1'b0, F1);
      add("ill_decode", BAD, 1'b1, 1'b0, DEC_ILL);
      add("j_fetch",   JMP, 1'b1, 1'b0, F1);
      add("j_decode",  JMP, 1'b1, 1'b0, DEC);
      add("j_ex",      JMP, 1'b1, 1'b0, JX);
      add("rst_fetch",  SW, 1'b1, 1'b0, F1);
      add("rst_decode", SW, 1'b1, 1'b0, DEC);
      add("rst_memadr", SW, 1'b1, 1'b0, MADR);
      add("rst_memwr",  SW, 1'b0, 1'b0, MWR);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

      // Still stalled in MEMWR; reset arrives mid-cycle.
      op = SW; memready = 1'b0;
      #1 check("memwr_stalled", 32'(act), 32'(MWR));
      reset = 1'b1;
      #1 check("reset_async", 32'(act), 32'(F0));
      @(posedge clk);
      #1 check("reset_over_edge", 32'(act), 32'(F0));
      @(negedge clk);
      reset = 1'b0; memready = 1'b1; op = LW;
      #1 check("release_fetch", 32'(act), 32'(F1));

      for (int i = 0; i < 6; i++) begin
         check($sformatf("nowait_state%0d", i), 32'(n_state), 32'(exp_st[i]));
         check($sformatf("nowait_regwrite%0d", i), 32'(n_regwrite), 32'(exp_rw[i]));
         @(negedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1);
   end

endmodule
